// File: rtl/dff_en_sync.sv
// Parameterizable D register with synchronous load enable and synchronous reset.
// Reset has priority over the enable, and Q is driven only by the register.
module dff_en_sync #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = D;
  end

  // Register stage: reset dominates, otherwise load-or-hold from q_d.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) q_q <= RST_VAL;
    else         q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: tb/tb_dff_en_sync.sv
// Scoreboard bench for dff_en_sync: a 1-bit default instance and an 8-bit
// instance with a non-zero reset value, each with its own reference model.
module tb_dff_en_sync;

  logic       clk;
  logic       rst1, en1, d1, q1;
  logic       rst8, en8;
  logic [7:0] d8, q8;

  int vectors;
  int miscompares;

  logic       m1;
  logic [7:0] m8;
  logic       sb1[$];
  logic [7:0] sb8[$];
  logic       exp1;
  logic [7:0] exp8;

  dff_en_sync u_dut1 (
    .sys_clk(clk), .sys_rst(rst1), .en(en1), .D(d1), .Q(q1)
  );

  dff_en_sync #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .sys_clk(clk), .sys_rst(rst8), .en(en8), .D(d8), .Q(q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge, predict the result, and step past the rising edge.
  task automatic apply1(input logic r, input logic e, input logic d);
    @(negedge clk);
    rst1 = r; en1 = e; d1 = d;
    if (r)      m1 = 1'b0;
    else if (e) m1 = d;
    sb1.push_back(m1);
    @(posedge clk);
    #1;
  endtask

  task automatic apply8(input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    rst8 = r; en8 = e; d8 = d;
    if (r)      m8 = 8'hA5;
    else if (e) m8 = d;
    sb8.push_back(m8);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply1(1'b1, 1'b0, 1'b0);
      exp1 = sb1.pop_front();
      vectors++;
      if (q1 !== exp1) begin
        $display("FAIL reset[%0d]: Q=%b expected %b", i, q1, exp1);
        miscompares++;
      end
    end
  endtask

  task automatic test_enable_low();
    logic dv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply1(1'b0, 1'b0, dv[i]);
      exp1 = sb1.pop_front();
      vectors++;
      if (q1 !== exp1) begin
        $display("FAIL enable_low[%0d]: Q=%b expected %b", i, q1, exp1);
        miscompares++;
      end
    end
  endtask

  task automatic test_load();
    logic dv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply1(1'b0, 1'b1, dv[i]);
      exp1 = sb1.pop_front();
      vectors++;
      if (q1 !== exp1) begin
        $display("FAIL load[%0d]: Q=%b expected %b", i, q1, exp1);
        miscompares++;
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 2; i++) begin
      apply1(1'b0, 1'b0, 1'b0);
      exp1 = sb1.pop_front();
      vectors++;
      if (q1 !== exp1) begin
        $display("FAIL hold[%0d]: Q=%b expected %b", i, q1, exp1);
        miscompares++;
      end
    end
    // Enabling with new data between edges must not reach Q before the next edge.
    en1 = 1'b1; d1 = 1'b0;
    #2;
    vectors++;
    if (q1 !== m1) begin
      $display("FAIL no_comb_path: Q=%b expected %b", q1, m1);
      miscompares++;
    end
  endtask

  task automatic test_reset_priority();
    logic rv[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply1(rv[i], 1'b1, 1'b1);
      exp1 = sb1.pop_front();
      vectors++;
      if (q1 !== exp1) begin
        $display("FAIL reset_priority[%0d]: Q=%b expected %b", i, q1, exp1);
        miscompares++;
      end
    end
  endtask

  task automatic test_width();
    logic       rv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       ev[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] dv[5] = '{8'h00, 8'hFF, 8'h3C, 8'hFF, 8'h00};
    for (int i = 0; i < 5; i++) begin
      apply8(rv[i], ev[i], dv[i]);
      exp8 = sb8.pop_front();
      vectors++;
      if (q8 !== exp8) begin
        $display("FAIL width8[%0d]: Q=%h expected %h", i, q8, exp8);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m1 = 1'bx;
    m8 = 8'hxx;
    rst1 = 1'b1; en1 = 1'b0; d1 = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; d8 = 8'h00;

    test_reset();
    test_enable_low();
    test_load();
    test_hold();
    test_reset_priority();
    test_width();

    if (sb1.size() != 0 || sb8.size() != 0) begin
      $display("FAIL scoreboard_drain: left=%0d required=0", sb1.size() + sb8.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
